uart_rx_byte: RTL
=================

UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; 8N1 framing only.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 data_out  output  DATA_BITS  last correctly framed byte, LSB received first.
REQ-007 data_valid  output  1  single-cycle pulse; data_out is new.
REQ-008 frame_error  output  1  single-cycle pulse; stop bit sampled low.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_sync) before any use; synchronizer flops reset to 1.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-012 A bit timer SHALL count 0..CLKS_PER_BIT-1 and clear on every state change.
REQ-013 IDLE: rx_sync==0 -> START.
REQ-014 START: at timer==CLKS_PER_BIT/2-1, rx_sync==0 -> DATA; rx_sync==1 -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: at each timer==CLKS_PER_BIT-1, rx_sync SHALL shift into the shift register at bit_idx; bit_idx SHALL run 0..DATA_BITS-1 and wrap to 0. After bit DATA_BITS-1 -> STOP.
REQ-016 Sampling instants SHALL be bit centres, i.e. CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles after the synchronized falling edge.
REQ-017 STOP: at timer==CLKS_PER_BIT-1:
- rx_sync==1: load data_out from the shift register, pulse data_valid on the next cycle, -> IDLE.
- rx_sync==0: pulse frame_error, leave data_out unchanged, -> BREAK.
REQ-018 BREAK: remain until rx_sync==1, then -> IDLE; a held-low line SHALL NOT be decoded as new frames.
REQ-019 data_valid and frame_error SHALL never be asserted in the same cycle and SHALL be high for exactly 1 cycle.
REQ-020 A start edge arriving in the cycle the FSM enters IDLE SHALL be accepted; back-to-back frames with zero idle time SHALL decode without loss.
REQ-021 data_out SHALL hold its value between valid frames.

Reset
REQ-022 Reset SHALL force state=IDLE, timer=0, bit_idx=0, shift register=0, data_out=0, data_valid=0, frame_error=0, busy=0, synchronizer=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; decoding SHALL resume with the next falling edge after reset deasserts.

Structure
REQ-024 Package uart_pkg SHALL hold the state enum (uart_rx_state_t) and the default CLKS_PER_BIT constant.
REQ-025 The bit timer SHALL be a sub-module, uart_bit_timer: parameterized width, sync clear, terminal-count output.
REQ-026 All other logic SHALL reside in uart_rx_byte; no latches, one clock domain.

Verification (CLKS_PER_BIT=16)
REQ-027 Frame 0xA5, 8N1 -> one data_valid pulse, data_out=0xA5, valid within 2 cycles after the stop-bit centre.
REQ-028 6-cycle low glitch on an idle line -> return to IDLE, no data_valid or frame_error, busy high for no more than 10 cycles.
REQ-029 0x3C with stop bit low, then line held low for 100 cycles -> one frame_error pulse, data_out unchanged, busy high until rx returns high.
REQ-030 Back-to-back 0x00, 0xFF, 0x55 with no idle bits -> three data_valid pulses in order with matching data_out.
REQ-031 Reset asserted during bit 4 of 0x81 -> no pulse, all outputs at reset values; following 0x7E decodes correctly.
REQ-032 Frame 0x5A at baud +/-3 % (bit time 15.5 / 16.5 cycles) -> data_out=0x5A, no frame_error.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path: the receiver
//                state encoding and the default bit period in clk cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // 100 MHz system clock, 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter. Counts 0..limit, wraps to 0
//                after reaching limit, and restarts from 0 on a synchronous
//                clear.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                clear - restart count from 0 on the next edge
//                limit - terminal count value
//                tc    - high while the count equals limit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] limit,
   output logic             tc
);

   logic [WIDTH-1:0] r_count;
   logic             w_tc;

   assign w_tc = (r_count == limit);
   assign tc   = w_tc;

   always_ff @(posedge clk) begin
      if (reset || clear || w_tc) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART receiver. Synchronizes rx, finds the start bit
//                centre, samples each data bit at its centre and checks the
//                stop bit. A low stop bit raises frame_error and parks the
//                receiver until the line returns high.
//  Ports       : clk         - system clock (posedge)
//                reset       - synchronous active-high reset
//                rx          - asynchronous serial input, idles high
//                data_out    - last correctly framed byte
//                data_valid  - 1-cycle pulse, data_out was just updated
//                frame_error - 1-cycle pulse, stop bit sampled low
//                busy        - receiver is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int c_TW = $clog2(CLKS_PER_BIT);
   localparam int c_IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [c_TW-1:0] c_FULL_M1  = c_TW'(CLKS_PER_BIT - 1);
   localparam logic [c_TW-1:0] c_HALF_M1  = c_TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(DATA_BITS - 1);

   logic                 r_rx_meta;
   logic                 r_rx_sync;
   uart_rx_state_t       r_state;
   uart_rx_state_t       w_next;
   logic [c_IW-1:0]      r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_data_valid;
   logic                 r_frame_error;

   logic                 w_tc;
   logic                 w_clear;
   logic [c_TW-1:0]      w_limit;
   logic                 w_shift_en;
   logic                 w_accept;
   logic                 w_ferr;

   // Two-flop synchronizer; resets to the idle line level so a reset does
   // not look like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   // START waits only half a bit so that every later terminal count falls
   // on a bit centre.
   assign w_limit = (r_state == START) ? c_HALF_M1 : c_FULL_M1;
   assign w_clear = (w_next != r_state);

   uart_bit_timer #(
      .WIDTH (c_TW)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .limit (w_limit),
      .tc    (w_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_shift_en = 1'b0;
      w_accept   = 1'b0;
      w_ferr     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!r_rx_sync) begin
               w_next = START;
            end
         end
         START: begin
            if (w_tc) begin
               w_next = r_rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_tc) begin
               w_shift_en = 1'b1;
               if (r_bit_idx == c_LAST_IDX) begin
                  w_next = STOP;
               end
            end
         end
         STOP: begin
            if (w_tc) begin
               w_accept = r_rx_sync;
               w_ferr   = !r_rx_sync;
               w_next   = r_rx_sync ? IDLE : BREAK;
            end
         end
         BREAK: begin
            if (r_rx_sync) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_data_out    <= '0;
         r_data_valid  <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_data_valid  <= w_accept;
         r_frame_error <= w_ferr;
         if (w_accept) begin
            r_data_out <= r_shift;
         end
         if (w_shift_en) begin
            r_shift[r_bit_idx] <= r_rx_sync;
            r_bit_idx          <= (r_bit_idx == c_LAST_IDX) ? '0 : r_bit_idx + 1'b1;
         end
      end
   end

   assign data_out    = r_data_out;
   assign data_valid  = r_data_valid;
   assign frame_error = r_frame_error;
   assign busy        = (r_state != IDLE);

endmodule : uart_rx_byte
`default_nettype wire
